// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
//   Shared types for the pipeline hazard/bypass logic.
//   REG_BITS   : register index width (register 0 is hardwired zero)
//   md_state_t : multdiv handshake FSM states
//   sb_entry_t : one in-flight destination record {v, dst, ld}
// ----------------------------------------------------------------------------
package proc_pkg;

   localparam int REG_BITS = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   typedef struct packed {
      logic                v;    // entry holds a real regfile write
      logic [REG_BITS-1:0] dst;  // destination register of that write
      logic                ld;   // the producer is a load
   } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_p_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_p_if
//   Bundle between the pipeline datapath (master) and the hazard controller
//   (slave). Clock and reset are not part of the bundle.
//   fd_*        : sources of the instruction in FD and whether it reads them
//   dx_*        : fields of the instruction in DX
//   xm_*        : store flag and data register of the XM instruction
//   md_ready    : multdiv result-ready pulse
//   sel_a/sel_b : ALU operand bypass selects (FWD_STAGES = regfile value)
//   sel_st      : store data from the MW writeback value
//   stall, dx_bubble, md_start, md_busy : pipeline control back to datapath
// ----------------------------------------------------------------------------
interface hazard_ctrl_p_if #(
   parameter int FWD_STAGES = 2,
   parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
   logic [proc_pkg::REG_BITS-1:0] fd_src_a;
   logic [proc_pkg::REG_BITS-1:0] fd_src_b;
   logic                          fd_use_a;
   logic                          fd_use_b;
   logic                          dx_valid;
   logic [proc_pkg::REG_BITS-1:0] dx_src_a;
   logic [proc_pkg::REG_BITS-1:0] dx_src_b;
   logic [proc_pkg::REG_BITS-1:0] dx_dst;
   logic                          dx_wr;
   logic                          dx_is_load;
   logic                          dx_is_md;
   logic                          xm_is_store;
   logic [proc_pkg::REG_BITS-1:0] xm_st_src;
   logic                          md_ready;
   logic [SEL_W-1:0]              sel_a;
   logic [SEL_W-1:0]              sel_b;
   logic                          sel_st;
   logic                          stall;
   logic                          dx_bubble;
   logic                          md_start;
   logic                          md_busy;

   modport master (
      output fd_src_a, fd_src_b, fd_use_a, fd_use_b,
      output dx_valid, dx_src_a, dx_src_b, dx_dst, dx_wr, dx_is_load, dx_is_md,
      output xm_is_store, xm_st_src, md_ready,
      input  sel_a, sel_b, sel_st, stall, dx_bubble, md_start, md_busy
   );

   modport slave (
      input  fd_src_a, fd_src_b, fd_use_a, fd_use_b,
      input  dx_valid, dx_src_a, dx_src_b, dx_dst, dx_wr, dx_is_load, dx_is_md,
      input  xm_is_store, xm_st_src, md_ready,
      output sel_a, sel_b, sel_st, stall, dx_bubble, md_start, md_busy
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// ----------------------------------------------------------------------------
// fwd_scoreboard
//   Shift register of in-flight destinations (entry 0 = XM, 1 = MW, ...)
//   plus a youngest-first priority match for two source registers.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_push       : record entering entry 0 this edge
//   i_src_a/b    : registers to look up
//   o_sel_a/b    : lowest matching entry index, FWD_STAGES when none
//   o_entries    : current scoreboard contents
// ----------------------------------------------------------------------------
module fwd_scoreboard
   import proc_pkg::*;
#(
   parameter int FWD_STAGES = 2,
   parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  sb_entry_t                      i_push,
   input  logic      [REG_BITS-1:0]       i_src_a,
   input  logic      [REG_BITS-1:0]       i_src_b,
   output logic      [SEL_W-1:0]          o_sel_a,
   output logic      [SEL_W-1:0]          o_sel_b,
   output sb_entry_t [FWD_STAGES-1:0]     o_entries
);

   sb_entry_t [FWD_STAGES-1:0] r_sb;

   // Scanning from the oldest entry down lets the youngest match overwrite.
   function automatic logic [SEL_W-1:0] f_match(input sb_entry_t [FWD_STAGES-1:0] sb,
                                                input logic [REG_BITS-1:0]       src);
      logic [SEL_W-1:0] sel;
      sel = SEL_W'(FWD_STAGES);
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (sb[k].v && (sb[k].dst == src) && (src != '0)) sel = SEL_W'(k);
      end
      return sel;
   endfunction

   // NOTE: non-blocking assignments make every entry shift from the old
   // value of its neighbour, independent of statement order.
   // NOTE: the whole register is cleared, not just v; dst/ld are don't-care
   // while v=0 but clearing them keeps the state free of X after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sb <= '0;
      end else begin
         r_sb[0] <= i_push;
         for (int k = 1; k < FWD_STAGES; k++) r_sb[k] <= r_sb[k-1];
      end
   end

   assign o_sel_a   = f_match(r_sb, i_src_a);
   assign o_sel_b   = f_match(r_sb, i_src_b);
   assign o_entries = r_sb;

endmodule

// File: rtl/hazard_ctrl_p.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_p
//   Hazard and bypass controller for the 5-stage pipeline: operand bypass
//   selects from a scoreboard of in-flight writes, load-use stall, store-data
//   bypass from MW, and the multdiv start/busy handshake.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   hz           : slave side of hazard_ctrl_p_if (see that file for signals)
// ----------------------------------------------------------------------------
module hazard_ctrl_p
   import proc_pkg::*;
#(
   parameter int FWD_STAGES = 2,
   parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
   input logic             clock,
   input logic             reset,
   hazard_ctrl_p_if.slave  hz
);

   md_state_t                  r_state;
   md_state_t                  w_state_nxt;
   logic                       r_md_busy;
   logic                       w_md_hold;
   logic                       w_md_start;
   logic                       w_load_use;
   sb_entry_t                  w_push;
   sb_entry_t [FWD_STAGES-1:0] w_entries;

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_md_hold   = 1'b0;
      w_md_start  = 1'b0;
      case (r_state)
         IDLE: begin
            if (hz.dx_valid && hz.dx_is_md) begin
               w_md_start  = 1'b1;
               w_md_hold   = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (hz.md_ready) w_state_nxt = IDLE;
            else             w_md_hold   = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_md_busy <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_md_busy <= (w_state_nxt == BUSY);
      end
   end

   // The load result is only available from MW, so a consumer right behind
   // the load must wait one cycle in FD.
   assign w_load_use = hz.dx_valid && hz.dx_is_load && (hz.dx_dst != '0) &&
                       ((hz.fd_use_a && (hz.fd_src_a == hz.dx_dst)) ||
                        (hz.fd_use_b && (hz.fd_src_b == hz.dx_dst)));

   // A held md instruction is still in DX; it enters the scoreboard only on
   // the cycle it actually leaves.
   assign w_push.v   = hz.dx_valid && hz.dx_wr && (hz.dx_dst != '0) && !w_md_hold;
   assign w_push.dst = hz.dx_dst;
   assign w_push.ld  = hz.dx_is_load;

   fwd_scoreboard #(
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
   ) u_sb (
      .clock     (clock),
      .reset     (reset),
      .i_push    (w_push),
      .i_src_a   (hz.dx_src_a),
      .i_src_b   (hz.dx_src_b),
      .o_sel_a   (hz.sel_a),
      .o_sel_b   (hz.sel_b),
      .o_entries (w_entries)
   );

   // Store data can come from the MW writeback only when an MW entry exists.
   generate
      if (FWD_STAGES >= 2) begin : g_st_bypass
         assign hz.sel_st = hz.xm_is_store && w_entries[1].v &&
                            (w_entries[1].dst == hz.xm_st_src) && (hz.xm_st_src != '0);
      end else begin : g_no_st_bypass
         assign hz.sel_st = 1'b0;
      end
   endgenerate

   assign hz.stall     = w_load_use | w_md_hold;
   assign hz.dx_bubble = w_load_use | w_md_hold;
   assign hz.md_start  = w_md_start;
   assign hz.md_busy   = r_md_busy;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
module tb_hazard_ctrl_p;

   typedef struct {
      logic       rst;
      logic [4:0] fa, fb;
      logic       ua, ub;
      logic       dv;
      logic [4:0] da, db, dd;
      logic       dw, dl, dm;
      logic       xs;
      logic [4:0] xsrc;
      logic       rdy;
      logic [1:0] e_sa, e_sb;
      logic       e_st, e_stall, e_bub, e_start, e_busy;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   vec_t vq[$];
   vec_t exp_q[$];

   hazard_ctrl_p_if #(.FWD_STAGES(2)) hz2 ();
   hazard_ctrl_p_if #(.FWD_STAGES(4)) hz4 ();

   hazard_ctrl_p #(.FWD_STAGES(2)) u_dut2 (.clock(clock), .reset(reset), .hz(hz2));
   hazard_ctrl_p #(.FWD_STAGES(4)) u_dut4 (.clock(clock), .reset(reset), .hz(hz4));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---- vector builders --------------------------------------------------
   function automatic vec_t nop();
      vec_t t;
      t = '{default: '0};
      t.e_sa = 2'd2;
      t.e_sb = 2'd2;
      return t;
   endfunction

   function automatic vec_t ins(input logic [4:0] d, input logic [4:0] a,
                                input logic [4:0] b, input logic wr);
      vec_t t;
      t    = nop();
      t.dv = 1'b1;
      t.dd = d;
      t.da = a;
      t.db = b;
      t.dw = wr;
      return t;
   endfunction

   function automatic vec_t sel(input vec_t t, input logic [1:0] sa, input logic [1:0] sb);
      t.e_sa = sa;
      t.e_sb = sb;
      return t;
   endfunction

   function automatic vec_t hzx(input vec_t t, input logic stl, input logic bub,
                                input logic start, input logic busy);
      t.e_stall = stl;
      t.e_bub   = bub;
      t.e_start = start;
      t.e_busy  = busy;
      return t;
   endfunction

   function automatic vec_t fd(input vec_t t, input logic [4:0] a, input logic ua,
                               input logic [4:0] b, input logic ub);
      t.fa = a;
      t.ua = ua;
      t.fb = b;
      t.ub = ub;
      return t;
   endfunction

   // Both DUTs see the same pipeline stimulus.
   task automatic drive(input vec_t t);
      reset          = t.rst;
      hz2.fd_src_a   = t.fa;   hz4.fd_src_a   = t.fa;
      hz2.fd_src_b   = t.fb;   hz4.fd_src_b   = t.fb;
      hz2.fd_use_a   = t.ua;   hz4.fd_use_a   = t.ua;
      hz2.fd_use_b   = t.ub;   hz4.fd_use_b   = t.ub;
      hz2.dx_valid   = t.dv;   hz4.dx_valid   = t.dv;
      hz2.dx_src_a   = t.da;   hz4.dx_src_a   = t.da;
      hz2.dx_src_b   = t.db;   hz4.dx_src_b   = t.db;
      hz2.dx_dst     = t.dd;   hz4.dx_dst     = t.dd;
      hz2.dx_wr      = t.dw;   hz4.dx_wr      = t.dw;
      hz2.dx_is_load = t.dl;   hz4.dx_is_load = t.dl;
      hz2.dx_is_md   = t.dm;   hz4.dx_is_md   = t.dm;
      hz2.xm_is_store = t.xs;  hz4.xm_is_store = t.xs;
      hz2.xm_st_src  = t.xsrc; hz4.xm_st_src  = t.xsrc;
      hz2.md_ready   = t.rdy;  hz4.md_ready   = t.rdy;
   endtask

   task automatic build_table();
      vec_t t;
      // reset state
      vq.push_back(nop());
      vq.push_back(ins(3, 3, 3, 1'b0));
      // bypass distance: back-to-back, youngest wins, drop-off to regfile
      vq.push_back(ins(3, 1, 2, 1'b1));
      vq.push_back(sel(ins(4, 3, 3, 1'b1), 2'd0, 2'd0));
      vq.push_back(ins(3, 1, 2, 1'b1));
      vq.push_back(nop());
      vq.push_back(sel(ins(5, 3, 4, 1'b1), 2'd1, 2'd2));
      vq.push_back(sel(ins(6, 1, 5, 1'b1), 2'd2, 2'd0));
      vq.push_back(nop());
      vq.push_back(nop());
      vq.push_back(ins(7, 6, 0, 1'b1));
      vq.push_back(sel(ins(7, 7, 1, 1'b1), 2'd0, 2'd2));
      vq.push_back(sel(ins(8, 7, 7, 1'b1), 2'd0, 2'd0));
      // write to r0 never enters the scoreboard; reading r0 never bypasses
      vq.push_back(ins(0, 1, 1, 1'b1));
      vq.push_back(sel(ins(9, 0, 8, 1'b1), 2'd2, 2'd1));
      // load-use: one stall cycle, consumer later resolves to MW
      t = fd(ins(5, 1, 0, 1'b1), 5, 1'b1, 1, 1'b1); t.dl = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b0, 1'b0));
      vq.push_back(fd(nop(), 5, 1'b1, 1, 1'b1));
      vq.push_back(sel(ins(6, 5, 1, 1'b1), 2'd1, 2'd2));
      t = fd(ins(10, 0, 0, 1'b1), 10, 1'b0, 11, 1'b1); t.dl = 1'b1;
      vq.push_back(t);
      t = fd(sel(ins(0, 6, 0, 1'b1), 2'd1, 2'd2), 0, 1'b1, 0, 1'b1); t.dl = 1'b1;
      vq.push_back(t);
      t = fd(ins(11, 1, 0, 1'b1), 3, 1'b0, 11, 1'b1); t.dl = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b0, 1'b0));
      t = fd(nop(), 11, 1'b1, 0, 1'b0); t.dl = 1'b1; t.dd = 11;
      vq.push_back(t);
      vq.push_back(sel(ins(12, 11, 0, 1'b1), 2'd1, 2'd2));
      // store-data bypass from MW
      vq.push_back(ins(9, 1, 0, 1'b1));
      vq.push_back(sel(ins(0, 2, 9, 1'b0), 2'd2, 2'd0));
      t = nop(); t.xs = 1'b1; t.xsrc = 9; t.e_st = 1'b1;
      vq.push_back(t);
      t = nop(); t.xs = 1'b1; t.xsrc = 9;
      vq.push_back(t);
      vq.push_back(ins(9, 1, 0, 1'b1));
      t = nop(); t.xs = 1'b1; t.xsrc = 9;
      vq.push_back(t);
      t = nop(); t.xsrc = 9;
      vq.push_back(t);
      // multdiv: start, 32 busy cycles, ready, dependent add
      t = ins(7, 1, 2, 1'b1); t.dm = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < 32; i++) vq.push_back(hzx(t, 1'b1, 1'b1, 1'b0, 1'b1));
      t.rdy = 1'b1;
      vq.push_back(hzx(t, 1'b0, 1'b0, 1'b0, 1'b1));
      t = sel(ins(8, 7, 1, 1'b1), 2'd0, 2'd2); t.rdy = 1'b1;
      vq.push_back(t);
      vq.push_back(nop());
      // back-to-back md with minimum occupancy
      t = ins(12, 1, 2, 1'b1); t.dm = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b1, 1'b0));
      t.rdy = 1'b1;
      vq.push_back(hzx(t, 1'b0, 1'b0, 1'b0, 1'b1));
      t = sel(ins(13, 12, 0, 1'b1), 2'd0, 2'd2); t.dm = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b1, 1'b0));
      t = sel(t, 2'd1, 2'd2); t.rdy = 1'b1;
      vq.push_back(hzx(t, 1'b0, 1'b0, 1'b0, 1'b1));
      vq.push_back(nop());
      // reset during BUSY cycle 5
      t = ins(14, 1, 2, 1'b1); t.dm = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < 4; i++) vq.push_back(hzx(t, 1'b1, 1'b1, 1'b0, 1'b1));
      t.rst = 1'b1;
      vq.push_back(hzx(t, 1'b1, 1'b1, 1'b0, 1'b1));
      t = ins(15, 14, 12, 1'b1); t.rdy = 1'b1;
      vq.push_back(t);
      vq.push_back(nop());
   endtask

   // A load can never be bypassed from XM to a real DX instruction.
   always @(negedge clock) begin
      if (!reset && hz2.dx_valid && (hz2.sel_a == 2'd0 || hz2.sel_b == 2'd0))
         check("ld_at_xm", 32'(u_dut2.w_entries[0].ld), 32'd0);
   end

   initial begin
      vec_t e;
      drive(nop());
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      build_table();

      foreach (vq[i]) begin
         drive(vq[i]);
         exp_q.push_back(vq[i]);
         @(negedge clock);
         e = exp_q.pop_front();
         check($sformatf("sel_a[%0d]", i),     32'(hz2.sel_a),     32'(e.e_sa));
         check($sformatf("sel_b[%0d]", i),     32'(hz2.sel_b),     32'(e.e_sb));
         check($sformatf("sel_st[%0d]", i),    32'(hz2.sel_st),    32'(e.e_st));
         check($sformatf("stall[%0d]", i),     32'(hz2.stall),     32'(e.e_stall));
         check($sformatf("dx_bubble[%0d]", i), 32'(hz2.dx_bubble), 32'(e.e_bub));
         check($sformatf("md_start[%0d]", i),  32'(hz2.md_start),  32'(e.e_start));
         check($sformatf("md_busy[%0d]", i),   32'(hz2.md_busy),   32'(e.e_busy));
         @(posedge clock);
         #1;
      end

      // FWD_STAGES=4: distance three bypass, then regfile
      drive(nop()); reset = 1'b1;
      @(posedge clock); #1;
      drive(ins(3, 1, 2, 1'b1));
      @(negedge clock);
      check("w4_reset_sel_a", 32'(hz4.sel_a), 32'd4);
      @(posedge clock); #1;
      repeat (3) begin
         drive(nop());
         @(posedge clock); #1;
      end
      drive(ins(4, 3, 3, 1'b1));
      @(negedge clock);
      check("w4_dist3_sel_a", 32'(hz4.sel_a), 32'd3);
      check("w4_dist3_sel_b", 32'(hz4.sel_b), 32'd3);
      @(posedge clock); #1;
      drive(ins(5, 4, 3, 1'b1));
      @(negedge clock);
      check("w4_b2b_sel_a", 32'(hz4.sel_a), 32'd0);
      check("w4_dropped_sel_b", 32'(hz4.sel_b), 32'd4);
      @(posedge clock); #1;
      drive(ins(0, 5, 0, 1'b1));
      @(posedge clock); #1;
      drive(nop());
      @(negedge clock);
      check("w4_r0_entry0_v", 32'(u_dut4.w_entries[0].v), 32'd0);
      check("w2_r0_entry0_v", 32'(u_dut2.w_entries[0].v), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_p.md
# hazard_ctrl_p

Parametrised hazard and bypass controller for the 5-stage pipelined processor. It replaces the fixed two-source bypass selector with a scoreboard of in-flight destination registers. The scoreboard depth is configurable, and the block also generates load-use stalls, store-data bypass and a multdiv busy/stall handshake. It sits beside the DX/XM/MW latches and drives the ALU operand muxes, the dmem data mux and the PC/FD/DX enables.

## Interface
Parameters:
- REG_BITS, 5, register index width; register 0 is hardwired zero.
- FWD_STAGES, 2, number of scoreboard entries and bypass sources (entry 0 = XM, entry 1 = MW, ...); range 1..6.
- SEL_W, $clog2(FWD_STAGES+1), width of the operand-select outputs.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- fd_src_a, fd_src_b  in  REG_BITS  source registers of the instruction in FD.
- fd_use_a, fd_use_b  in  1  FD instruction actually reads that source.
- dx_valid  in  1  DX holds a real instruction (not a bubble).
- dx_src_a, dx_src_b  in  REG_BITS  source registers of the DX instruction.
- dx_dst  in  REG_BITS  destination of the DX instruction.
- dx_wr  in  1  DX instruction writes the regfile.
- dx_is_load  in  1  DX instruction is lw.
- dx_is_md  in  1  DX instruction is mul/div.
- xm_is_store, xm_st_src  in  1, REG_BITS  XM instruction is sw, and its data register.
- md_ready  in  1  multdiv result-ready pulse.
- sel_a, sel_b  out  SEL_W  operand source: k<FWD_STAGES selects entry k; FWD_STAGES selects the regfile/latch value.
- sel_st  out  1  store data is taken from the MW writeback value.
- stall  out  1  hold PC and the FD latch.
- dx_bubble  out  1  load a nop into the DX latch.
- md_start  out  1  one-cycle start pulse to multdiv.
- md_busy  out  1  FSM is in BUSY.

## Operation
- The scoreboard is FWD_STAGES entries of {v, dst, ld}. Each edge, entry k moves to k+1 and the last entry is dropped. Downstream stages never stall.
- Entry 0 loads {dx_valid & dx_wr & (dst!=0) & ~hold, dx_dst, dx_is_load}. hold = the md stall term below.
- Operand select:
  - sel_a is the lowest k with v[k] & dst[k]==dx_src_a & dx_src_a!=0; if none, sel_a = FWD_STAGES. sel_b is the same using dx_src_b.
  - The youngest match wins.
- Load-use hazard:
  - Condition: dx_valid & dx_is_load & dx_dst!=0, and (fd_use_a & fd_src_a==dx_dst) or (fd_use_b & fd_src_b==dx_dst).
  - Response: stall=1 and dx_bubble=1 for exactly one cycle.
  - On the next cycle the load sits in entry 0 and the consumer is still in FD. The consumer enters DX one cycle later and sel resolves to entry 1.
- A match on an entry with ld=1 at k=0 cannot occur by construction. The bench asserts this.
- Store bypass: sel_st = xm_is_store & v[1] & dst[1]==xm_st_src & xm_st_src!=0.
- MD FSM, states IDLE and BUSY:
  - IDLE with dx_valid & dx_is_md: md_start=1, stall=1, dx_bubble=1, hold=1; next state BUSY.
  - BUSY with md_ready=0: stall=1, dx_bubble=1, hold=1, md_busy=1.
  - BUSY with md_ready=1: all stall terms are 0, so the md instruction leaves DX and enters entry 0 normally; next state IDLE.
  - md_ready in IDLE is ignored.
- stall and dx_bubble are the OR of the load-use and MD terms. Simultaneous load-use and MD requests cannot both arise from DX; if they do, the outputs are simply ORed.

## Timing
- All outputs are combinational from state plus the current inputs, except md_busy, which is registered.
- Reset values: every v bit = 0, FSM = IDLE, md_busy = 0. Consequently sel_a = sel_b = FWD_STAGES, and sel_st, stall, dx_bubble and md_start are 0 unless an input condition asserts them.
- Reset asserted mid-BUSY forces IDLE on the next edge and clears the scoreboard. A pending md_ready is ignored.
- Minimum multdiv occupancy of DX is 2 cycles (start, then ready).
- A back-to-back md instruction starts on the cycle after the ready cycle.

## Structure
- Shared package `proc_pkg`: REG_BITS, the md_state_t enum {IDLE, BUSY}, and the scoreboard entry struct.
- Sub-module `fwd_scoreboard`: the shift register plus the priority match, instantiated once with two lookup ports. The FSM and load-use logic stay in the top module.

## Test plan
- FWD_STAGES=2, add r3 then add r4,r3,r3 back-to-back: sel_a=sel_b=0. One nop between them: sel=1. Two nops: sel=2 (regfile).
- lw r5 followed by add r6,r5,r1: one cycle with stall=dx_bubble=1, then the consumer reaches DX with sel_a=1 and stall=0.
- Write to r0 in DX, consumer reads r0: sel=FWD_STAGES, and no entry has v set.
- mul r7 with md_ready after 33 cycles: md_start pulses once, stall held 33 cycles, md_busy=1 throughout. The next add r8,r7 sees sel_a=0.
- addi r9 then sw r9 (data from MW): sel_st=1 in the cycle the sw is in XM.
- Reset asserted in BUSY cycle 5: next cycle IDLE, stall=0, all sel=FWD_STAGES. Rerun the first scenario with FWD_STAGES=4 and confirm sel=3 after three nops.
